// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver with 16x oversampling and 3-sample majority vote.
// Define UART_RX_PARITY_EN to add a parity bit (sense set by PARITY_ODD).
module uart_byte_rx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_RXD_Rx,
  input  logic [2:0] i_RXD_Baud,
  output logic [7:0] o_RXD_Dout,
  output logic       o_RXD_Done,
  output logic       o_RXD_FrameErr,
  output logic       o_RXD_ParErr,
  output logic       o_RXD_State
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif

  localparam logic [15:0] DIV0 = 16'(CLK_FREQ / (9600 * 16) - 1);
  localparam logic [15:0] DIV1 = 16'(CLK_FREQ / (19200 * 16) - 1);
  localparam logic [15:0] DIV2 = 16'(CLK_FREQ / (38400 * 16) - 1);
  localparam logic [15:0] DIV3 = 16'(CLK_FREQ / (57600 * 16) - 1);
  localparam logic [15:0] DIV4 = 16'(CLK_FREQ / (115200 * 16) - 1);

  logic        r_sync1;
  logic        r_sync2;
  logic        r_sync3;
  logic [2:0]  r_state;
  logic [2:0]  r_baud;
  logic [15:0] r_div_cnt;
  logic [3:0]  r_smp_cnt;
  logic [2:0]  r_bit_cnt;
  logic        r_s7;
  logic        r_s8;
  logic [7:0]  r_shift;
  logic [7:0]  r_dout;
  logic        r_done;
  logic        r_ferr;
`ifdef UART_RX_PARITY_EN
  logic        r_par_bad;
  logic        r_perr;
`endif

  logic [15:0] w_div;
  logic        w_fall;
  logic        w_tick;
  logic        w_maj;
  logic        w_at9;
  logic        w_at15;

  always_comb begin
    w_div = DIV0;
    case (r_baud)
      3'd1:    w_div = DIV1;
      3'd2:    w_div = DIV2;
      3'd3:    w_div = DIV3;
      3'd4:    w_div = DIV4;
      default: w_div = DIV0;
    endcase
  end

  assign w_fall = r_sync3 & ~r_sync2;
  assign w_tick = (r_div_cnt == w_div);
  assign w_maj  = (r_s7 & r_s8) | (r_s7 & r_sync2) | (r_s8 & r_sync2);
  assign w_at9  = w_tick && (r_smp_cnt == 4'd9);
  assign w_at15 = w_tick && (r_smp_cnt == 4'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
    end else begin
      r_sync1 <= i_RXD_Rx;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_baud    <= 3'd0;
      r_div_cnt <= 16'd0;
      r_smp_cnt <= 4'd0;
      r_bit_cnt <= 3'd0;
      r_s7      <= 1'b0;
      r_s8      <= 1'b0;
      r_shift   <= 8'h00;
      r_dout    <= 8'h00;
      r_done    <= 1'b0;
      r_ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= 1'b0;
      r_perr    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr <= 1'b0;
`endif
      if (r_state == IDLE) begin
        r_div_cnt <= 16'd0;
        r_smp_cnt <= 4'd0;
        r_bit_cnt <= 3'd0;
        r_s7      <= 1'b0;
        r_s8      <= 1'b0;
`ifdef UART_RX_PARITY_EN
        r_par_bad <= 1'b0;
`endif
        if (w_fall) begin
          r_state <= START;
          r_baud  <= i_RXD_Baud;
        end
      end else begin
        r_div_cnt <= w_tick ? 16'd0 : r_div_cnt + 16'd1;
        if (w_tick) begin
          r_smp_cnt <= r_smp_cnt + 4'd1;
          if (r_smp_cnt == 4'd7) r_s7 <= r_sync2;
          if (r_smp_cnt == 4'd8) r_s8 <= r_sync2;
        end
        case (r_state)
          START: begin
            if (w_at9 && w_maj) r_state <= IDLE;
            else if (w_at15)    r_state <= DATA;
          end
          DATA: begin
            if (w_at9) r_shift <= {w_maj, r_shift[7:1]};
            if (w_at15) begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
`ifdef UART_RX_PARITY_EN
              if (r_bit_cnt == 3'd7) r_state <= PARITY;
`else
              if (r_bit_cnt == 3'd7) r_state <= STOP;
`endif
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (w_at9)  r_par_bad <= w_maj ^ (^r_shift) ^ PARITY_ODD;
            if (w_at15) r_state   <= STOP;
          end
`endif
          STOP: begin
            // Leave mid-stop-bit so a following start edge is not missed
            if (w_at9) begin
              if (w_maj) begin
                r_dout <= r_shift;
                r_done <= 1'b1;
              end else begin
                r_ferr <= 1'b1;
              end
`ifdef UART_RX_PARITY_EN
              r_perr <= r_par_bad;
`endif
              r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_RXD_Dout     = r_dout;
  assign o_RXD_Done     = r_done;
  assign o_RXD_FrameErr = r_ferr;
  assign o_RXD_State    = (r_state != IDLE);
`ifdef UART_RX_PARITY_EN
  assign o_RXD_ParErr   = r_perr;
`else
  assign o_RXD_ParErr   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_byte_rx.sv
// Scoreboarded bench for uart_byte_rx: directed frames, glitch,
// framing error, mid-frame reset and (when enabled) parity checks.
module tb_uart_byte_rx;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [2:0] baud;
  logic [7:0] dout;
  logic       done;
  logic       ferr;
  logic       perr;
  logic       state;

  uart_byte_rx #(
    .CLK_FREQ  (50_000_000),
    .PARITY_ODD(1'b0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_RXD_Rx      (rx),
    .i_RXD_Baud    (baud),
    .o_RXD_Dout    (dout),
    .o_RXD_Done    (done),
    .o_RXD_FrameErr(ferr),
    .o_RXD_ParErr  (perr),
    .o_RXD_State   (state)
  );

  typedef struct {
    bit         is_ferr;
    logic [7:0] data;
    bit         par_err;
    bit         lat_chk;
    longint     due;
  } exp_t;

  exp_t   q[$];
  int     checks = 0;
  int     passes = 0;
  longint cyc = 0;
  bit     prev_pulse = 1'b0;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic int div_of(input int b);
    case (b)
      1:       return 50_000_000 / (19200 * 16) - 1;
      2:       return 50_000_000 / (38400 * 16) - 1;
      3:       return 50_000_000 / (57600 * 16) - 1;
      4:       return 50_000_000 / (115200 * 16) - 1;
      default: return 50_000_000 / (9600 * 16) - 1;
    endcase
  endfunction

  // Monitor: every output pulse must match the head of the queue
  always @(negedge clk) begin
    if (rst_n && (done || ferr || perr)) begin
      check("pulse_width", 32'(prev_pulse), 32'd0);
      if (q.size() == 0) begin
        check("spurious", {29'd0, done, ferr, perr}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("done", 32'(done), 32'(!e.is_ferr));
        check("ferr", 32'(ferr), 32'(e.is_ferr));
        check("parerr", 32'(perr), 32'(e.par_err));
        if (!e.is_ferr) check("dout", 32'(dout), 32'(e.data));
        if (e.lat_chk) begin
          checks++;
          if (cyc >= e.due - 2 && cyc <= e.due + 2) passes++;
          else $display("FAIL latency: got cycle %0d expected %0d", cyc, e.due);
        end
      end
    end
    prev_pulse = done || ferr;
  end

  task automatic drive_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input logic par, input bit scramble);
    int bt;
    bt = 16 * (div_of(int'(baud)) + 1);
    drive_bit(1'b0, bt);
    if (scramble) baud = ~baud;
    for (int i = 0; i < 8; i++) drive_bit(d[i], bt);
`ifdef UART_RX_PARITY_EN
    drive_bit(par, bt);
`else
    if (par) rx = 1'b1;
`endif
    drive_bit(stop, bt);
    if (scramble) baud = ~baud;
    rx = 1'b1;
  endtask

  task automatic expect_evt(input bit is_f, input logic [7:0] d,
                            input bit pe, input bit lat, input longint due);
    exp_t e;
    e.is_ferr = is_f;
    e.data    = d;
    e.par_err = pe;
    e.lat_chk = lat;
    e.due     = due;
    q.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    longint lat;
    rst_n = 1'b0;
    rx    = 1'b1;
    baud  = 3'd4;
    repeat (4) @(posedge clk);
    #1;
    check("rst_dout", 32'(dout), 32'h00);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ferr", 32'(ferr), 32'd0);
    check("rst_perr", 32'(perr), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // 1: 0x55 at 115200, latency, baud changed mid-frame
    lat = 4161;
`ifdef UART_RX_PARITY_EN
    lat = lat + 432;
`endif
    expect_evt(1'b0, 8'h55, 1'b0, 1'b1, cyc + lat);
    send_frame(8'h55, 1'b1, 1'b0, 1'b1);
    wait_drain(2000);

    // 2: back-to-back frames at 57600
    baud = 3'd3;
    expect_evt(1'b0, 8'hA3, 1'b0, 1'b0, 0);
    expect_evt(1'b0, 8'h0F, 1'b0, 1'b0, 0);
    send_frame(8'hA3, 1'b1, 1'b0, 1'b0);
    send_frame(8'h0F, 1'b1, 1'b0, 1'b0);
    wait_drain(4000);
    check("b2b_dout", 32'(dout), 32'h0F);

    // 3: 200 ns glitch on idle line
    baud = 3'd4;
    drive_bit(1'b0, 10);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("glitch_start", 32'(state), 32'd1);
    repeat (432) @(posedge clk);
    #1;
    check("glitch_idle", 32'(state), 32'd0);

    // 4: framing error at 38400, Dout held
    baud = 3'd2;
    expect_evt(1'b1, 8'h00, 1'b0, 1'b0, 0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    wait_drain(4000);
    check("ferr_dout_held", 32'(dout), 32'h0F);
    drive_bit(1'b1, 2000);

    // 5: reset during data bit 4 of 0xFF, then 0x81
    baud = 3'd4;
    drive_bit(1'b0, 432);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 432);
    drive_bit(1'b1, 216);
    check("mid_state", 32'(state), 32'd1);
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_dout", 32'(dout), 32'h00);
    rst_n = 1'b1;
    drive_bit(1'b1, 864);
    check("post_rst_state", 32'(state), 32'd0);
    expect_evt(1'b0, 8'h81, 1'b0, 1'b0, 0);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    wait_drain(2000);

`ifdef UART_RX_PARITY_EN
    // 6: even parity on 0x07
    expect_evt(1'b0, 8'h07, 1'b1, 1'b0, 0);
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    wait_drain(2000);
    expect_evt(1'b0, 8'h07, 1'b0, 1'b0, 0);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    wait_drain(2000);
`endif

    drive_bit(1'b1, 500);
    check("final_idle", 32'(state), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
